// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if
// Groups the hazard controller's pipeline-facing signals.
//   master : pipeline side, drives the ID/EX sources and consumes the controls
//   slave  : hazard_ctrl, consumes the sources and drives the controls/counters
// Ports (all from the pipeline's view):
//   id_valid, id_rs1, id_rs2, id_uses_rs2    ID-stage instruction fields
//   ex_MemRead, ex_rd, ex_branch_taken       ID/EX register outputs
//   pc_write, ifid_write, idex_bubble,       front-end hold / bubble /
//   ifid_flush, busy                         flush controls, FSM busy flag
//   stall_count, flush_count                 saturating performance counters
interface hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             id_valid;
   logic [4:0]       id_rs1;
   logic [4:0]       id_rs2;
   logic             id_uses_rs2;
   logic             ex_MemRead;
   logic [4:0]       ex_rd;
   logic             ex_branch_taken;
   logic             pc_write;
   logic             ifid_write;
   logic             idex_bubble;
   logic             ifid_flush;
   logic             busy;
   logic [CNT_W-1:0] stall_count;
   logic [CNT_W-1:0] flush_count;

   modport master (
      output id_valid, id_rs1, id_rs2, id_uses_rs2,
             ex_MemRead, ex_rd, ex_branch_taken,
      input  pc_write, ifid_write, idex_bubble, ifid_flush, busy,
             stall_count, flush_count
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_uses_rs2,
             ex_MemRead, ex_rd, ex_branch_taken,
      output pc_write, ifid_write, idex_bubble, ifid_flush, busy,
             stall_count, flush_count
   );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Load-use stall and taken-branch flush controller for a 5-stage pipeline.
// Controls are combinational from state + inputs (zero-latency response);
// state, remaining-cycle counter and perf counters update on rising clk.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   hz     hazard_ctrl_if.slave (pipeline fields in, controls/counters out)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_RUN   | normal flow; reacts to branch (flush) or load-use (stall)
// ST_STALL | extra load-use hold cycles; r_rem = cycles left after this one
// ST_FLUSH | extra flush cycles after a taken branch; r_rem as above
module hazard_ctrl #(
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int FLUSH_CYCLES      = 1,
   parameter int CNT_W             = 32
) (
   input  logic          clk,
   input  logic          reset,
   hazard_ctrl_if.slave  hz
);

   typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_FLUSH} state_t;

   // First hazard cycle is handled in RUN, so the extra-state reload is N-2.
   localparam logic [3:0] STALL_RELOAD = 4'((LOAD_STALL_CYCLES > 1) ? (LOAD_STALL_CYCLES - 2) : 0);
   localparam logic [3:0] FLUSH_RELOAD = 4'((FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [3:0]       r_rem;
   logic [3:0]       w_rem_nxt;
   logic [CNT_W-1:0] r_stall_count;
   logic [CNT_W-1:0] r_flush_count;
   logic             w_lu;
   logic             w_pc_write;
   logic             w_ifid_write;
   logic             w_idex_bubble;
   logic             w_ifid_flush;
   logic             w_stall_inc;
   logic             w_flush_inc;

   // x0 is never a real producer, so ex_rd==0 can never stall.
   assign w_lu = hz.id_valid & hz.ex_MemRead & (hz.ex_rd != 5'd0) &
                 ((hz.ex_rd == hz.id_rs1) | (hz.id_uses_rs2 & (hz.ex_rd == hz.id_rs2)));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= ST_RUN;
         r_rem         <= 4'd0;
         r_stall_count <= '0;
         r_flush_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_rem   <= w_rem_nxt;
         if (w_stall_inc && (r_stall_count != {CNT_W{1'b1}}))
            r_stall_count <= r_stall_count + 1'b1;
         if (w_flush_inc && (r_flush_count != {CNT_W{1'b1}}))
            r_flush_count <= r_flush_count + 1'b1;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_rem_nxt     = r_rem;
      w_pc_write    = 1'b1;
      w_ifid_write  = 1'b1;
      w_idex_bubble = 1'b0;
      w_ifid_flush  = 1'b0;
      w_stall_inc   = 1'b0;
      w_flush_inc   = 1'b0;

      // A taken branch wins in every state, including aborting a stall.
      if (hz.ex_branch_taken) begin
         w_ifid_flush  = 1'b1;
         w_idex_bubble = 1'b1;
         w_flush_inc   = 1'b1;
         w_rem_nxt     = FLUSH_RELOAD;
         w_state_nxt   = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_lu) begin
                  w_pc_write    = 1'b0;
                  w_ifid_write  = 1'b0;
                  w_idex_bubble = 1'b1;
                  w_stall_inc   = 1'b1;
                  if (LOAD_STALL_CYCLES > 1) begin
                     w_state_nxt = ST_STALL;
                     w_rem_nxt   = STALL_RELOAD;
                  end
               end
            end
            ST_STALL: begin
               w_pc_write    = 1'b0;
               w_ifid_write  = 1'b0;
               w_idex_bubble = 1'b1;
               w_stall_inc   = 1'b1;
               if (r_rem == 4'd0) w_state_nxt = ST_RUN;
               else               w_rem_nxt   = r_rem - 4'd1;
            end
            ST_FLUSH: begin
               w_ifid_flush  = 1'b1;
               w_idex_bubble = 1'b1;
               if (r_rem == 4'd0) w_state_nxt = ST_RUN;
               else               w_rem_nxt   = r_rem - 4'd1;
            end
            default: begin
               w_state_nxt = ST_RUN;
               w_rem_nxt   = 4'd0;
            end
         endcase
      end

      // Hold the front end and squash IF/ID/ID/EX while reset is asserted.
      if (reset) begin
         w_pc_write    = 1'b0;
         w_ifid_write  = 1'b0;
         w_idex_bubble = 1'b1;
         w_ifid_flush  = 1'b1;
         w_stall_inc   = 1'b0;
         w_flush_inc   = 1'b0;
         w_state_nxt   = ST_RUN;
         w_rem_nxt     = 4'd0;
      end
   end

   assign hz.pc_write    = w_pc_write;
   assign hz.ifid_write  = w_ifid_write;
   assign hz.idex_bubble = w_idex_bubble;
   assign hz.ifid_flush  = w_ifid_flush;
   assign hz.busy        = (r_state != ST_RUN);
   assign hz.stall_count = r_stall_count;
   assign hz.flush_count = r_flush_count;

endmodule
